// File: rtl/sr_flag_sequencer.sv
// Round-robin command sequencer in front of an SR flag bank: one S or R strobe per
// transaction, flag state held locally, one-cycle ack (plus err for bad indices) per grant.
module sr_flag_sequencer #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IW    = $clog2(NFLAG)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    op,
   input  logic [IW*NREQ-1:0]   idx,
   output logic [NREQ-1:0]      ack,
   output logic                 err,
   output logic [NFLAG-1:0]     s_vec,
   output logic [NFLAG-1:0]     r_vec,
   output logic [NFLAG-1:0]     flags,
   output logic                 busy
);

   localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_TOG = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [WW-1:0]    ptr_q, ptr_d;
   logic [WW-1:0]    win_q, win_d;
   logic             oor_q, oor_d;
   logic [NFLAG-1:0] flags_q, flags_d;
   logic [NFLAG-1:0] s_q, s_d;
   logic [NFLAG-1:0] r_q, r_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic [1:0]       op_a  [NREQ];
   logic [IW-1:0]    idx_a [NREQ];
   logic             found_s;
   logic [WW-1:0]    j_s;
   logic [WW-1:0]    win_s;
   logic [1:0]       op_s;
   logic [IW-1:0]    idx_s;
   logic             oor_s;
   logic [NFLAG-1:0] s_st;
   logic [NFLAG-1:0] r_st;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign op_a[g]  = op[2*g +: 2];
      assign idx_a[g] = idx[IW*g +: IW];
   end

   // Round-robin search starting at ptr_q; first requester found wins.
   always_comb begin
      found_s = 1'b0;
      j_s     = '0;
      win_s   = '0;
      op_s    = 2'b00;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j_s = WW'((int'(ptr_q) + k) % NREQ);
         if (!found_s && req[j_s]) begin
            found_s = 1'b1;
            win_s   = j_s;
            op_s    = op_a[j_s];
            idx_s   = idx_a[j_s];
         end else begin
            found_s = found_s;
         end
      end
      oor_s = (int'(idx_s) >= NFLAG);
   end

   // Strobe decode for the winning command; flags are stable while IDLE so toggle can look ahead.
   always_comb begin
      s_st = '0;
      r_st = '0;
      if (!oor_s) begin
         case (op_s)
            OP_SET: s_st[idx_s] = 1'b1;
            OP_CLR: r_st[idx_s] = 1'b1;
            OP_TOG: begin
               if (flags_q[idx_s]) begin
                  r_st[idx_s] = 1'b1;
               end else begin
                  s_st[idx_s] = 1'b1;
               end
            end
            default: s_st = '0;
         endcase
      end else begin
         s_st = '0;
      end
   end

   // Sequencer next state; strobes, ack and err are registered so they never see req/op/idx directly.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      oor_d   = oor_q;
      s_d     = '0;
      r_d     = '0;
      ack_d   = '0;
      err_d   = 1'b0;
      flags_d = (flags_q | s_q) & ~r_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d = ST_APPLY;
               win_d   = win_s;
               oor_d   = oor_s;
               s_d     = s_st;
               r_d     = r_st;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_APPLY: begin
            state_d        = ST_ACK;
            ack_d[win_q]   = 1'b1;
            err_d          = oor_q;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            ptr_d   = (win_q == WW'(NREQ - 1)) ? '0 : win_q + WW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         oor_q   <= 1'b0;
         flags_q <= '0;
         s_q     <= '0;
         r_q     <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         oor_q   <= oor_d;
         flags_q <= flags_d;
         s_q     <= s_d;
         r_q     <= r_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign s_vec = s_q;
   assign r_vec = r_q;
   assign flags = flags_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_sr_flag_sequencer.sv
// Directed bench for sr_flag_sequencer: an 8-flag instance and a 6-flag instance
// (out-of-range indices), single-transaction vector table plus multi-requester sequences.
module tb_sr_flag_sequencer;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_TOG = 2'b11;

   typedef struct {
      bit         d6;
      logic [1:0] rid;
      logic [1:0] op;
      logic [2:0] idx;
      logic [7:0] s;
      logic [7:0] r;
      logic [7:0] fl;
      logic       err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  req8, req6;
   logic [1:0]  op8_a [4];
   logic [1:0]  op6_a [4];
   logic [2:0]  idx8_a [4];
   logic [2:0]  idx6_a [4];
   logic [7:0]  op8, op6;
   logic [11:0] idx8, idx6;
   logic [3:0]  ack8, ack6;
   logic        err8, err6, busy8, busy6;
   logic [7:0]  s8, r8, fl8;
   logic [5:0]  s6, r6, fl6;

   assign op8  = {op8_a[3], op8_a[2], op8_a[1], op8_a[0]};
   assign op6  = {op6_a[3], op6_a[2], op6_a[1], op6_a[0]};
   assign idx8 = {idx8_a[3], idx8_a[2], idx8_a[1], idx8_a[0]};
   assign idx6 = {idx6_a[3], idx6_a[2], idx6_a[1], idx6_a[0]};

   sr_flag_sequencer #(.NREQ(4), .NFLAG(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req(req8), .op(op8), .idx(idx8),
      .ack(ack8), .err(err8), .s_vec(s8), .r_vec(r8), .flags(fl8), .busy(busy8)
   );

   sr_flag_sequencer #(.NREQ(4), .NFLAG(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .req(req6), .op(op6), .idx(idx6),
      .ack(ack6), .err(err6), .s_vec(s6), .r_vec(r6), .flags(fl6), .busy(busy6)
   );

   bit         sel6;
   logic [7:0] m_s, m_r, m_fl;
   logic [3:0] m_ack;
   logic       m_err, m_busy;

   always_comb begin
      m_s = s8; m_r = r8; m_fl = fl8; m_ack = ack8; m_err = err8; m_busy = busy8;
      if (sel6) begin
         m_s = {2'b00, s6}; m_r = {2'b00, r6}; m_fl = {2'b00, fl6};
         m_ack = ack6; m_err = err6; m_busy = busy6;
      end
   end

   int   n_vec  = 0;
   int   n_miss = 0;
   vec_t tv [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and check the strobe/ack invariants of both instances.
   task automatic cyc();
      @(negedge clk);
      chk("sr_overlap8", 32'(s8 & r8), 32'd0);
      chk("s_onehot8",   32'($onehot0(s8)), 32'd1);
      chk("r_onehot8",   32'($onehot0(r8)), 32'd1);
      chk("ack_onehot8", 32'($onehot0(ack8)), 32'd1);
      chk("sr_overlap6", 32'(s6 & r6), 32'd0);
      chk("s_onehot6",   32'($onehot0(s6)), 32'd1);
      chk("ack_onehot6", 32'($onehot0(ack6)), 32'd1);
   endtask

   task automatic drive(input bit d6, input logic [1:0] rid, input logic [1:0] o, input logic [2:0] i);
      if (d6) begin
         req6[rid] = 1'b1; op6_a[rid] = o; idx6_a[rid] = i;
      end else begin
         req8[rid] = 1'b1; op8_a[rid] = o; idx8_a[rid] = i;
      end
   endtask

   task automatic release_req(input bit d6, input logic [1:0] rid);
      if (d6) begin
         req6[rid] = 1'b0; op6_a[rid] = OP_NOP; idx6_a[rid] = 3'd0;
      end else begin
         req8[rid] = 1'b0; op8_a[rid] = OP_NOP; idx8_a[rid] = 3'd0;
      end
   endtask

   // One isolated transaction started from IDLE: strobe in cycle 1, ack/flags in cycle 2, idle in cycle 3.
   task automatic run_txn(input vec_t v);
      sel6 = v.d6;
      drive(v.d6, v.rid, v.op, v.idx);
      cyc();
      chk("txn_s_vec", 32'(m_s), 32'(v.s));
      chk("txn_r_vec", 32'(m_r), 32'(v.r));
      chk("txn_busy1", 32'(m_busy), 32'd1);
      chk("txn_ack1",  32'(m_ack), 32'd0);
      cyc();
      chk("txn_ack",   32'(m_ack), 32'd1 << v.rid);
      chk("txn_err",   32'(m_err), 32'(v.err));
      chk("txn_flags", 32'(m_fl), 32'(v.fl));
      chk("txn_busy2", 32'(m_busy), 32'd1);
      release_req(v.d6, v.rid);
      cyc();
      chk("txn_busy3", 32'(m_busy), 32'd0);
      chk("txn_ack3",  32'(m_ack), 32'd0);
   endtask

   // Bounded wait for the next ack on the 8-flag instance, then the requester drops its req.
   task automatic wait_ack(input logic [1:0] rid, input logic [7:0] exp_fl, input int exp_gap);
      int w;
      w = 0;
      do begin
         cyc();
         w++;
      end while (ack8 == 4'd0 && w < 8);
      chk("seq_ack",   32'(ack8), 32'd1 << rid);
      chk("seq_gap",   32'(w), 32'(exp_gap));
      chk("seq_flags", 32'(fl8), 32'(exp_fl));
      chk("seq_err",   32'(err8), 32'd0);
      release_req(1'b0, rid);
   endtask

   // All four requesters post at once (requester i targets flag i); grants must start at 'start'.
   task automatic rr_round(input logic [1:0] start, input logic [1:0] opc, input logic [7:0] fl0);
      logic [1:0] k;
      logic [7:0] e;
      e = fl0;
      sel6 = 1'b0;
      for (int n = 0; n < 4; n++) begin
         k = 2'(n);
         drive(1'b0, k, opc, 3'(n));
      end
      for (int n = 0; n < 4; n++) begin
         k = start + 2'(n);
         e = (opc == OP_SET) ? (e | (8'd1 << k)) : (e & ~(8'd1 << k));
         wait_ack(k, e, (n == 0) ? 2 : 3);
      end
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      sel6 = 1'b0;
      req8 = 4'd0;
      req6 = 4'd0;
      for (int i = 0; i < 4; i++) begin
         op8_a[i] = OP_NOP; op6_a[i] = OP_NOP; idx8_a[i] = 3'd0; idx6_a[i] = 3'd0;
      end

      //           d6    rid    op      idx    s      r      flags  err
      tv[0]  = '{1'b0, 2'd0, OP_CLR, 3'd3, 8'h00, 8'h08, 8'h00, 1'b0};
      tv[1]  = '{1'b0, 2'd1, OP_SET, 3'd5, 8'h20, 8'h00, 8'h20, 1'b0};
      tv[2]  = '{1'b0, 2'd1, OP_CLR, 3'd5, 8'h00, 8'h20, 8'h00, 1'b0};
      tv[3]  = '{1'b0, 2'd2, OP_TOG, 3'd0, 8'h01, 8'h00, 8'h01, 1'b0};
      tv[4]  = '{1'b0, 2'd2, OP_TOG, 3'd0, 8'h00, 8'h01, 8'h00, 1'b0};
      tv[5]  = '{1'b0, 2'd3, OP_NOP, 3'd4, 8'h00, 8'h00, 8'h00, 1'b0};
      tv[6]  = '{1'b0, 2'd0, OP_CLR, 3'd2, 8'h00, 8'h04, 8'h00, 1'b0};
      tv[7]  = '{1'b0, 2'd0, OP_SET, 3'd7, 8'h80, 8'h00, 8'h80, 1'b0};
      tv[8]  = '{1'b0, 2'd3, OP_TOG, 3'd7, 8'h00, 8'h80, 8'h00, 1'b0};
      tv[9]  = '{1'b1, 2'd0, OP_SET, 3'd5, 8'h20, 8'h00, 8'h20, 1'b0};
      tv[10] = '{1'b1, 2'd1, OP_SET, 3'd6, 8'h00, 8'h00, 8'h20, 1'b1};
      tv[11] = '{1'b1, 2'd2, OP_NOP, 3'd2, 8'h00, 8'h00, 8'h20, 1'b0};
      tv[12] = '{1'b1, 2'd3, OP_TOG, 3'd7, 8'h00, 8'h00, 8'h20, 1'b1};
      tv[13] = '{1'b1, 2'd0, OP_TOG, 3'd5, 8'h00, 8'h20, 8'h00, 1'b0};

      // Reset state, both instances.
      repeat (3) cyc();
      chk("rst_flags8", 32'(fl8), 32'd0);
      chk("rst_ack8",   32'(ack8), 32'd0);
      chk("rst_busy8",  32'(busy8), 32'd0);
      chk("rst_err8",   32'(err8), 32'd0);
      chk("rst_s8",     32'(s8 | r8), 32'd0);
      chk("rst_flags6", 32'(fl6), 32'd0);
      chk("rst_busy6",  32'(busy6), 32'd0);
      rst_n = 1'b1;
      cyc();
      chk("idle_busy8", 32'(busy8), 32'd0);

      // Reset in the middle of APPLY discards the transaction; held req is re-granted afterwards.
      drive(1'b0, 2'd0, OP_SET, 3'd3);
      cyc();
      chk("pre_rst_s", 32'(s8), 32'h08);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 32'(fl8), 32'd0);
      chk("mid_rst_ack",   32'(ack8), 32'd0);
      chk("mid_rst_busy",  32'(busy8), 32'd0);
      chk("mid_rst_s",     32'(s8), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("regrant_s",    32'(s8), 32'h08);
      chk("regrant_busy", 32'(busy8), 32'd1);
      cyc();
      chk("regrant_ack",   32'(ack8), 32'd1);
      chk("regrant_flags", 32'(fl8), 32'h08);
      release_req(1'b0, 2'd0);
      cyc();

      for (int t = 0; t < 14; t++) run_txn(tv[t]);
      sel6 = 1'b0;

      // ptr is 0 here (last single grant was requester 3).
      rr_round(2'd0, OP_SET, 8'h00);
      v = '{1'b0, 2'd1, OP_NOP, 3'd0, 8'h00, 8'h00, 8'h0F, 1'b0};
      run_txn(v);
      rr_round(2'd2, OP_CLR, 8'h0F);

      // Bring ptr back to 0, then two requesters race for flag 7.
      v = '{1'b0, 2'd3, OP_NOP, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
      run_txn(v);
      drive(1'b0, 2'd0, OP_SET, 3'd7);
      drive(1'b0, 2'd1, OP_CLR, 3'd7);
      wait_ack(2'd0, 8'h80, 2);
      wait_ack(2'd1, 8'h00, 3);
      cyc();
      chk("end_busy", 32'(busy8), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
